// File: rtl/bsg_axi_bridge_pkg.sv
// Shared types for the AXI memory request bridge.
// Optional response checking in the top is enabled by defining BSG_AXI_BRIDGE_RESP_CHECK_EN.
package bsg_axi_bridge_pkg;

    // One transaction in flight: address phase, data phase, then (for writes) response.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5
    } bridge_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/bsg_axi_mem_req_bridge.sv
// AXI4 burst master: converts a valid/ready memory request into a single AW/W/B or
// AR/R transaction, passing write beats in and read beats out with zero latency.
// Macro BSG_AXI_BRIDGE_RESP_CHECK_EN: when defined, error_o latches (until reset) any
// non-OKAY response, unexpected BID/RID, or RLAST disagreeing with the beat count.
module bsg_axi_mem_req_bridge
    import bsg_axi_bridge_pkg::*;
#(
    parameter int axi_id_width_p    = 4,
    parameter int axi_addr_width_p  = 32,
    parameter int axi_data_width_p  = 64,
    parameter int axi_len_width_p   = 8,
    parameter int axi_id_p          = 0,
    localparam int axi_strb_width_lp = axi_data_width_p >> 3
) (
    input  logic                          clk_i,
    input  logic                          aresetn_i,

    input  logic                          req_v_i,
    output logic                          req_ready_o,
    input  logic                          req_write_i,
    input  logic [axi_addr_width_p-1:0]   req_addr_i,
    input  logic [axi_len_width_p-1:0]    req_len_i,

    input  logic                          wdata_v_i,
    output logic                          wdata_ready_o,
    input  logic [axi_data_width_p-1:0]   wdata_i,
    input  logic [axi_strb_width_lp-1:0]  wstrb_i,

    output logic                          rdata_v_o,
    input  logic                          rdata_ready_i,
    output logic [axi_data_width_p-1:0]   rdata_o,
    output logic                          rdata_last_o,

    output logic                          wr_done_o,
    output logic                          error_o,

    output logic [axi_id_width_p-1:0]     m_axi_awid_o,
    output logic [axi_addr_width_p-1:0]   m_axi_awaddr_o,
    output logic [axi_len_width_p-1:0]    m_axi_awlen_o,
    output logic                          m_axi_awvalid_o,
    input  logic                          m_axi_awready_i,

    output logic [axi_data_width_p-1:0]   m_axi_wdata_o,
    output logic [axi_strb_width_lp-1:0]  m_axi_wstrb_o,
    output logic                          m_axi_wlast_o,
    output logic                          m_axi_wvalid_o,
    input  logic                          m_axi_wready_i,

    input  logic [axi_id_width_p-1:0]     m_axi_bid_i,
    input  logic [1:0]                    m_axi_bresp_i,
    input  logic                          m_axi_bvalid_i,
    output logic                          m_axi_bready_o,

    output logic [axi_id_width_p-1:0]     m_axi_arid_o,
    output logic [axi_addr_width_p-1:0]   m_axi_araddr_o,
    output logic [axi_len_width_p-1:0]    m_axi_arlen_o,
    output logic                          m_axi_arvalid_o,
    input  logic                          m_axi_arready_i,

    input  logic [axi_id_width_p-1:0]     m_axi_rid_i,
    input  logic [axi_data_width_p-1:0]   m_axi_rdata_i,
    input  logic [1:0]                    m_axi_rresp_i,
    input  logic                          m_axi_rlast_i,
    input  logic                          m_axi_rvalid_i,
    output logic                          m_axi_rready_o
);

    localparam int lp_lg_strb = $clog2(axi_strb_width_lp);
    localparam logic [axi_id_width_p-1:0] lp_id = axi_id_width_p'(axi_id_p);

    bridge_state_e                 r_state;
    bridge_state_e                 w_next;
    logic [axi_addr_width_p-1:0]   r_addr;
    logic [axi_len_width_p-1:0]    r_len;
    logic [axi_id_width_p-1:0]     r_id;
    logic [axi_len_width_p-1:0]    r_cnt;

    logic w_req_hs;
    logic w_w_hs;
    logic w_r_hs;
    logic w_last;

    assign w_req_hs = (r_state == S_IDLE) & req_v_i;
    assign w_w_hs   = (r_state == S_W) & wdata_v_i & m_axi_wready_i;
    assign w_r_hs   = (r_state == S_R) & m_axi_rvalid_i & rdata_ready_i;
    // Last beat is derived from our own count so a misbehaving RLAST cannot desync us;
    // the count never wraps because it clears exactly when it reaches r_len.
    assign w_last   = (r_cnt == r_len);

    // State register
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_v_i)             w_next = req_write_i ? S_AW : S_AR;
            S_AW:   if (m_axi_awready_i)     w_next = S_W;
            S_W:    if (w_w_hs && w_last)    w_next = S_B;
            S_B:    if (m_axi_bvalid_i)      w_next = S_IDLE;
            S_AR:   if (m_axi_arready_i)     w_next = S_R;
            S_R:    if (w_r_hs && w_last)    w_next = S_IDLE;
            default:                         w_next = S_IDLE;
        endcase
    end

    // Request fields are captured once and held until the burst completes, since the
    // slave keeps sampling AxLEN for the whole burst.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_addr <= '0;
            r_len  <= '0;
            r_id   <= '0;
        end else if (w_req_hs) begin
            r_addr <= {req_addr_i[axi_addr_width_p-1:lp_lg_strb], {lp_lg_strb{1'b0}}};
            r_len  <= req_len_i;
            r_id   <= lp_id;
        end
    end

    // Beat counter shared by the W and R data phases
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i)              r_cnt <= '0;
        else if (w_w_hs || w_r_hs)   r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end

    // Outputs decoded from state; data channels are straight pass-through
    always_comb begin
        req_ready_o     = (r_state == S_IDLE);
        m_axi_awvalid_o = (r_state == S_AW);
        m_axi_arvalid_o = (r_state == S_AR);
        m_axi_wvalid_o  = (r_state == S_W) & wdata_v_i;
        wdata_ready_o   = (r_state == S_W) & m_axi_wready_i;
        m_axi_wlast_o   = (r_state == S_W) & w_last;
        m_axi_bready_o  = (r_state == S_B);
        wr_done_o       = (r_state == S_B) & m_axi_bvalid_i;
        rdata_v_o       = (r_state == S_R) & m_axi_rvalid_i;
        m_axi_rready_o  = (r_state == S_R) & rdata_ready_i;
        rdata_last_o    = (r_state == S_R) & w_last;
    end

    assign m_axi_awid_o   = r_id;
    assign m_axi_arid_o   = r_id;
    assign m_axi_awaddr_o = r_addr;
    assign m_axi_araddr_o = r_addr;
    assign m_axi_awlen_o  = r_len;
    assign m_axi_arlen_o  = r_len;
    assign m_axi_wdata_o  = wdata_i;
    assign m_axi_wstrb_o  = wstrb_i;
    assign rdata_o        = m_axi_rdata_i;

`ifdef BSG_AXI_BRIDGE_RESP_CHECK_EN
    logic r_error;
    logic w_b_bad;
    logic w_r_bad;

    assign w_b_bad = (r_state == S_B) & m_axi_bvalid_i &
                     ((m_axi_bresp_i != OKAY) | (m_axi_bid_i != lp_id));
    assign w_r_bad = w_r_hs &
                     ((m_axi_rresp_i != OKAY) | (m_axi_rid_i != lp_id) | (m_axi_rlast_i != w_last));

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i)              r_error <= 1'b0;
        else if (w_b_bad || w_r_bad) r_error <= 1'b1;
    end

    assign error_o = r_error;
`else
    logic w_unused_resp;
    assign w_unused_resp = ^{m_axi_bid_i, m_axi_bresp_i, m_axi_rid_i, m_axi_rresp_i, m_axi_rlast_i};
    assign error_o       = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_axi_mem_req_bridge.sv
// Bridge driven by a randomized requester against a behavioural AXI memory slave
// (1024 x 64-bit words, unwritten words read as 0xdeadbeefdeadbeef).
module tb_bsg_axi_mem_req_bridge;

    localparam logic [63:0] INIT = 64'hdeadbeefdeadbeef;

    logic        clk_i = 0;
    logic        aresetn_i;
    logic        req_v_i, req_ready_o, req_write_i;
    logic [31:0] req_addr_i;
    logic [7:0]  req_len_i;
    logic        wdata_v_i, wdata_ready_o;
    logic [63:0] wdata_i;
    logic [7:0]  wstrb_i;
    logic        rdata_v_o, rdata_ready_i, rdata_last_o;
    logic [63:0] rdata_o;
    logic        wr_done_o, error_o;
    logic [3:0]  m_axi_awid_o, m_axi_arid_o, m_axi_bid_i, m_axi_rid_i;
    logic [31:0] m_axi_awaddr_o, m_axi_araddr_o;
    logic [7:0]  m_axi_awlen_o, m_axi_arlen_o, m_axi_wstrb_o;
    logic        m_axi_awvalid_o, m_axi_awready_i, m_axi_wlast_o, m_axi_wvalid_o, m_axi_wready_i;
    logic [63:0] m_axi_wdata_o, m_axi_rdata_i;
    logic [1:0]  m_axi_bresp_i, m_axi_rresp_i;
    logic        m_axi_bvalid_i, m_axi_bready_o, m_axi_arvalid_o, m_axi_arready_i;
    logic        m_axi_rlast_i, m_axi_rvalid_i, m_axi_rready_o;

    bsg_axi_mem_req_bridge #(
        .axi_id_width_p(4), .axi_addr_width_p(32), .axi_data_width_p(64),
        .axi_len_width_p(8), .axi_id_p(3)
    ) dut (
        .clk_i(clk_i), .aresetn_i(aresetn_i),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wdata_v_i(wdata_v_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .rdata_v_o(rdata_v_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o), .rdata_last_o(rdata_last_o),
        .wr_done_o(wr_done_o), .error_o(error_o),
        .m_axi_awid_o(m_axi_awid_o), .m_axi_awaddr_o(m_axi_awaddr_o), .m_axi_awlen_o(m_axi_awlen_o),
        .m_axi_awvalid_o(m_axi_awvalid_o), .m_axi_awready_i(m_axi_awready_i),
        .m_axi_wdata_o(m_axi_wdata_o), .m_axi_wstrb_o(m_axi_wstrb_o), .m_axi_wlast_o(m_axi_wlast_o),
        .m_axi_wvalid_o(m_axi_wvalid_o), .m_axi_wready_i(m_axi_wready_i),
        .m_axi_bid_i(m_axi_bid_i), .m_axi_bresp_i(m_axi_bresp_i), .m_axi_bvalid_i(m_axi_bvalid_i),
        .m_axi_bready_o(m_axi_bready_o),
        .m_axi_arid_o(m_axi_arid_o), .m_axi_araddr_o(m_axi_araddr_o), .m_axi_arlen_o(m_axi_arlen_o),
        .m_axi_arvalid_o(m_axi_arvalid_o), .m_axi_arready_i(m_axi_arready_i),
        .m_axi_rid_i(m_axi_rid_i), .m_axi_rdata_i(m_axi_rdata_i), .m_axi_rresp_i(m_axi_rresp_i),
        .m_axi_rlast_i(m_axi_rlast_i), .m_axi_rvalid_i(m_axi_rvalid_i), .m_axi_rready_o(m_axi_rready_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // ---------------- behavioural AXI slave ----------------
    logic [63:0] smem [1024];
    logic        swr  [1024];
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
    logic [1:0]  s_bresp;
    logic [63:0] s_rdata;
    logic        s_wbusy, s_rbusy;
    logic [9:0]  s_widx, s_wcnt, s_wlen, s_ridx, s_rcnt;
    bit          force_berr = 0;

    function automatic logic [63:0] srd(input logic [9:0] i);
        return (swr[i] === 1'b1) ? smem[i] : INIT;
    endfunction

    assign m_axi_awready_i = s_awready;
    assign m_axi_wready_i  = s_wready;
    assign m_axi_bvalid_i  = s_bvalid;
    assign m_axi_bresp_i   = s_bresp;
    assign m_axi_bid_i     = 4'd3;
    assign m_axi_arready_i = s_arready;
    assign m_axi_rvalid_i  = s_rvalid;
    assign m_axi_rdata_i   = s_rdata;
    assign m_axi_rlast_i   = s_rlast;
    assign m_axi_rresp_i   = 2'b00;
    assign m_axi_rid_i     = 4'd3;

    // Slave: random ready/valid timing; rlast follows the live ARLEN, as the real slave does
    always @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            s_awready <= 0; s_wready <= 0; s_bvalid <= 0; s_bresp <= 0;
            s_arready <= 0; s_rvalid <= 0; s_rdata <= 0; s_rlast <= 0;
            s_wbusy <= 0; s_rbusy <= 0; s_widx <= 0; s_wcnt <= 0; s_wlen <= 0;
            s_ridx <= 0; s_rcnt <= 0;
        end else begin
            if (m_axi_awvalid_o && s_awready) begin
                s_awready <= 0; s_wbusy <= 1; s_widx <= m_axi_awaddr_o[12:3];
                s_wlen <= {2'b00, m_axi_awlen_o}; s_wcnt <= 0;
            end else s_awready <= !s_wbusy && !s_bvalid && ($urandom_range(0, 1) == 1);

            if (m_axi_wvalid_o && s_wready) begin
                smem[s_widx + s_wcnt] <= merge(srd(s_widx + s_wcnt), m_axi_wdata_o, m_axi_wstrb_o);
                swr[s_widx + s_wcnt]  <= 1'b1;
                s_wcnt <= s_wcnt + 1;
                if (s_wcnt == s_wlen) begin
                    s_wbusy <= 0; s_wready <= 0; s_bvalid <= 1;
                    s_bresp <= force_berr ? 2'b10 : 2'b00;
                end else s_wready <= ($urandom_range(0, 3) != 0);
            end else s_wready <= s_wbusy && ($urandom_range(0, 3) != 0);

            if (s_bvalid && m_axi_bready_o) s_bvalid <= 0;

            if (m_axi_arvalid_o && s_arready) begin
                s_arready <= 0; s_rbusy <= 1; s_ridx <= m_axi_araddr_o[12:3]; s_rcnt <= 0;
            end else s_arready <= !s_rbusy && ($urandom_range(0, 1) == 1);

            if (s_rvalid && m_axi_rready_o) begin
                s_rvalid <= 0; s_rcnt <= s_rcnt + 1;
                if (s_rlast) s_rbusy <= 0;
            end else if (s_rbusy && !s_rvalid && ($urandom_range(0, 3) != 0)) begin
                s_rvalid <= 1; s_rdata <= srd(s_ridx + s_rcnt);
                s_rlast  <= (s_rcnt == {2'b00, m_axi_arlen_o});
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [63:0] rmem [1024];
    bit          rval [1024];
    function automatic logic [63:0] rrd(input int i);
        return rval[i] ? rmem[i] : INIT;
    endfunction

    typedef struct { bit is_done; logic [63:0] data; bit last; } exp_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; } areq_t;
    typedef struct { logic [63:0] data; logic [7:0] strb; bit last; } wexp_t;
    exp_t  sbq[$];
    areq_t aq[$];
    wexp_t wq[$];

    exp_t  m_e;
    areq_t m_a;
    wexp_t m_w;
    logic [7:0] cur_arlen = 0;

    // Monitor: samples on the falling edge; a handshake seen here completes on the next rise
    always @(negedge clk_i) if (aresetn_i) begin
        if ((m_axi_awvalid_o && m_axi_awready_i) || (m_axi_arvalid_o && m_axi_arready_i)) begin
            if (aq.size() == 0) chk("addr_unexpected", 1, 0);
            else begin
                m_a = aq.pop_front();
                if (m_axi_awvalid_o) begin
                    chk("awaddr", m_axi_awaddr_o, m_a.addr);
                    chk("awlen", m_axi_awlen_o, m_a.len);
                    chk("awid", m_axi_awid_o, 3);
                end else begin
                    chk("araddr", m_axi_araddr_o, m_a.addr);
                    chk("arlen", m_axi_arlen_o, m_a.len);
                    chk("arid", m_axi_arid_o, 3);
                    cur_arlen = m_a.len;
                end
            end
        end
        if (m_axi_wvalid_o && m_axi_wready_i) begin
            if (wq.size() == 0) chk("wbeat_unexpected", 1, 0);
            else begin
                m_w = wq.pop_front();
                chk("wdata", m_axi_wdata_o, m_w.data);
                chk("wstrb", m_axi_wstrb_o, m_w.strb);
                chk("wlast", m_axi_wlast_o, m_w.last);
            end
        end
        if (rdata_v_o && rdata_ready_i) begin
            chk("arlen_stable", m_axi_arlen_o, cur_arlen);
            if (sbq.size() == 0) chk("rbeat_unexpected", 1, 0);
            else begin
                m_e = sbq.pop_front();
                chk("rbeat_kind", m_e.is_done, 0);
                chk("rdata", rdata_o, m_e.data);
                chk("rdata_last", rdata_last_o, m_e.last);
            end
        end
        if (wr_done_o) begin
            if (sbq.size() == 0) chk("wr_done_unexpected", 1, 0);
            else begin
                m_e = sbq.pop_front();
                chk("wr_done_kind", m_e.is_done, 1);
            end
        end
    end

    // ---------------- requester ----------------
    int rmode = 0;   // 0 random, 1 toggle, 2 always ready
    initial begin
        rdata_ready_i = 0;
        forever begin
            @(posedge clk_i); #1;
            case (rmode)
                0:       rdata_ready_i = ($urandom_range(0, 1) == 1);
                1:       rdata_ready_i = ~rdata_ready_i;
                default: rdata_ready_i = 1;
            endcase
        end
    end

    logic [63:0] wd[$];
    logic [7:0]  ws[$];

    task automatic pulse_req(input bit wr, input logic [31:0] addr, input int len);
        int n = 0;
        while (!req_ready_o && n < 3000) begin @(posedge clk_i); #1; n++; end
        chk("req_ready_wait_timeout", (n >= 3000), 0);
        req_v_i = 1; req_write_i = wr; req_addr_i = addr; req_len_i = 8'(len);
        @(posedge clk_i); #1;
        req_v_i = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sbq.size() != 0 || wq.size() != 0 || aq.size() != 0 || !req_ready_o) && n < 3000) begin
            @(posedge clk_i); #1; n++;
        end
        chk("txn_timeout", (n >= 3000), 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input int abort_at);
        int  base = int'(addr[12:3]);
        bit  hs;
        int  n;
        aq.push_back('{addr & ~32'h7, 8'(len)});
        for (int i = 0; i <= len; i++) begin
            wq.push_back('{wd[i], ws[i], (i == len)});
            if (abort_at < 0) begin
                rmem[(base + i) % 1024] = merge(rrd((base + i) % 1024), wd[i], ws[i]);
                rval[(base + i) % 1024] = 1;
            end
        end
        if (abort_at < 0) sbq.push_back('{1, 64'h0, 1});
        pulse_req(1, addr, len);
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin wdata_v_i = 0; @(posedge clk_i); #1; end
            wdata_i = wd[i]; wstrb_i = ws[i]; wdata_v_i = 1;
            if (i == abort_at) begin
                @(negedge clk_i);
                aresetn_i = 0;
                #1;
                chk("abort_axi_valids", {m_axi_awvalid_o, m_axi_wvalid_o, m_axi_arvalid_o,
                                         m_axi_bready_o, m_axi_rready_o, wdata_ready_o, rdata_v_o}, 0);
                chk("abort_awaddr", m_axi_awaddr_o, 0);
                chk("abort_awlen", m_axi_awlen_o, 0);
                wdata_v_i = 0;
                sbq.delete(); wq.delete(); aq.delete();
                repeat (3) @(posedge clk_i);
                #1 aresetn_i = 1;
                @(posedge clk_i); #1;
                chk("req_ready_after_reset", req_ready_o, 1);
                chk("error_after_reset", error_o, 0);
                return;
            end
            n = 0;
            do begin
                @(negedge clk_i); hs = wdata_v_i && wdata_ready_o;
                @(posedge clk_i); #1; n++;
            end while (!hs && n < 500);
            chk("wbeat_timeout", !hs, 0);
            if (!hs) break;
        end
        wdata_v_i = 0;
        wait_done();
    endtask

    task automatic do_read(input logic [31:0] addr, input int len);
        int base = int'(addr[12:3]);
        aq.push_back('{addr & ~32'h7, 8'(len)});
        for (int i = 0; i <= len; i++) sbq.push_back('{0, rrd((base + i) % 1024), (i == len)});
        pulse_req(0, addr, len);
        wait_done();
    endtask

    task automatic rand_data(input int len, input bit full);
        wd.delete(); ws.delete();
        for (int i = 0; i <= len; i++) begin
            wd.push_back({$urandom, $urandom});
            ws.push_back(full ? 8'hFF : 8'($urandom_range(0, 255)));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int len, idx;
        logic exp_err;
        for (int i = 0; i < 1024; i++) rval[i] = 0;
        aresetn_i = 0; req_v_i = 0; req_write_i = 0; req_addr_i = 0; req_len_i = 0;
        wdata_v_i = 0; wdata_i = 0; wstrb_i = 0;
        repeat (3) @(posedge clk_i); #1;
        chk("rst_valids", {m_axi_awvalid_o, m_axi_wvalid_o, m_axi_arvalid_o, m_axi_bready_o,
                           m_axi_rready_o, wdata_ready_o, rdata_v_o, wr_done_o}, 0);
        chk("rst_error", error_o, 0);
        chk("rst_addr", {m_axi_awaddr_o, m_axi_araddr_o}, 0);
        chk("rst_len_id", {m_axi_awlen_o, m_axi_arlen_o, m_axi_awid_o}, 0);
        aresetn_i = 1;
        @(posedge clk_i); #1;
        chk("idle_req_ready", req_ready_o, 1);

        // 1: write 1..4 then read back
        wd = '{64'd1, 64'd2, 64'd3, 64'd4}; ws = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_write(32'h100, 3, -1);
        do_read(32'h100, 3);
        // 2: single-beat read of untouched memory
        do_read(32'h200, 0);
        // 3: partial-strobe write then read
        wd = '{64'h1122334455667788}; ws = '{8'h0F};
        do_write(32'h300, 0, -1);
        do_read(32'h300, 0);
        // 4: toggling rdata_ready on a len 7 read
        rmode = 1;
        rand_data(7, 1);
        do_write(32'h400, 7, -1);
        do_read(32'h400, 7);
        rmode = 0;

        // Random traffic, unaligned addresses, no 4KB crossing
        for (int t = 0; t < 12; t++) begin
            len = $urandom_range(0, 15);
            idx = $urandom_range(0, 511 - len) + 512 * $urandom_range(0, 1);
            rand_data(len, 0);
            do_write(32'(idx * 8 + $urandom_range(0, 7)), len, -1);
            do_read(32'(idx * 8 + $urandom_range(0, 7)), len);
        end
        // Maximum burst length: counter reaches 255 and must not wrap early
        rmode = 2;
        do_read(32'h1000, 255);
        rmode = 0;

        // 6: slave error response on B
`ifdef BSG_AXI_BRIDGE_RESP_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        chk("error_before_berr", error_o, 0);
        force_berr = 1;
        rand_data(1, 1);
        do_write(32'h500, 1, -1);
        force_berr = 0;
        chk("error_after_berr", error_o, exp_err);
        do_read(32'h500, 1);
        chk("error_sticky", error_o, exp_err);

        // 5: reset during beat 2 of a len 3 write, then normal traffic
        rand_data(3, 1);
        do_write(32'h800, 3, 1);
        rand_data(2, 0);
        do_write(32'h608, 2, -1);
        do_read(32'h608, 2);

        chk("sbq_empty", sbq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
